// File: rtl/axi_inst_rom_rd.sv
// AXI4 read-only responder over a host-loadable word memory, used for instruction cache-fill bursts.
// Handshake: a transfer happens on any CLK edge where VALID && READY; the responder never drops RVALID or changes R payload until RREADY.
module axi_inst_rom_rd #(
    parameter int                                C_S_AXI_THREAD_ID_WIDTH = 1,
    parameter int                                C_S_AXI_ADDR_WIDTH      = 32,
    parameter int                                C_S_AXI_DATA_WIDTH      = 32,
    parameter int                                C_S_AXI_ARUSER_WIDTH    = 1,
    parameter int                                C_S_AXI_RUSER_WIDTH     = 4,
    parameter int                                C_MEM_DEPTH_LOG2        = 12,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0]     C_BASE_ADDR             = 32'h2000_0000
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                LOAD_EN,
    input  logic [C_MEM_DEPTH_LOG2-1:0]         LOAD_ADDR,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       LOAD_DATA,
    input  logic [C_S_AXI_THREAD_ID_WIDTH-1:0]  S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
    input  logic [7:0]                          S_AXI_ARLEN,
    input  logic [2:0]                          S_AXI_ARSIZE,
    input  logic [1:0]                          S_AXI_ARBURST,
    input  logic [1:0]                          S_AXI_ARLOCK,
    input  logic [3:0]                          S_AXI_ARCACHE,
    input  logic [2:0]                          S_AXI_ARPROT,
    input  logic [3:0]                          S_AXI_ARQOS,
    input  logic [C_S_AXI_ARUSER_WIDTH-1:0]     S_AXI_ARUSER,
    input  logic                                S_AXI_ARVALID,
    output logic                                S_AXI_ARREADY,
    output logic [C_S_AXI_THREAD_ID_WIDTH-1:0]  S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
    output logic [1:0]                          S_AXI_RRESP,
    output logic                                S_AXI_RLAST,
    output logic [C_S_AXI_RUSER_WIDTH-1:0]      S_AXI_RUSER,
    output logic                                S_AXI_RVALID,
    input  logic                                S_AXI_RREADY,
    output logic [1:0]                          DBG_STATE
);

    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int DEPTH = 1 << C_MEM_DEPTH_LOG2;
    // One past the last valid byte address, one bit wider so it cannot wrap.
    localparam logic [AW:0] C_END_ADDR =
        {1'b0, C_BASE_ADDR} + ((AW+1)'(1) << (C_MEM_DEPTH_LOG2 + 2));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_BEAT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [C_S_AXI_THREAD_ID_WIDTH-1:0] id_q;
    logic [AW-1:0]                      addr_q;
    logic [7:0]                         cnt_q;
    logic                               fixed_q;
    logic                               slverr_q;

    logic          ar_hs, r_hs, out_rng;
    logic [AW-1:0] next_addr, rd_addr, rd_off;
    logic [1:0]    beat_resp;
    logic [C_MEM_DEPTH_LOG2-1:0] rd_idx;

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] mem_q;

    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_hs  = S_AXI_RVALID && S_AXI_RREADY;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (ar_hs) state_nxt = ST_PREP;
            ST_PREP: state_nxt = ST_BEAT;
            ST_BEAT: if (r_hs && cnt_q == 8'd0) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            id_q     <= '0;
            addr_q   <= '0;
            cnt_q    <= 8'd0;
            fixed_q  <= 1'b0;
            slverr_q <= 1'b0;
        end else if (ar_hs) begin
            id_q     <= S_AXI_ARID;
            addr_q   <= {S_AXI_ARADDR[AW-1:2], 2'b00};
            cnt_q    <= S_AXI_ARLEN;
            fixed_q  <= (S_AXI_ARBURST == 2'b00);
            slverr_q <= (S_AXI_ARSIZE != 3'b010) || S_AXI_ARBURST[1];
        end else if (r_hs && cnt_q != 8'd0) begin
            cnt_q  <= cnt_q - 8'd1;
            addr_q <= next_addr;
        end
    end

    // Look ahead to the next beat on a handshake so beats stream back-to-back.
    assign next_addr = fixed_q ? addr_q : addr_q + AW'(4);
    assign rd_addr   = r_hs ? next_addr : addr_q;
    assign rd_off    = rd_addr - C_BASE_ADDR;
    assign rd_idx    = rd_off[C_MEM_DEPTH_LOG2+1:2];

    always_ff @(posedge CLK) begin
        if (LOAD_EN) mem[LOAD_ADDR] <= LOAD_DATA;
        mem_q <= mem[rd_idx];
    end

    // Range is judged on the full beat address, not on the wrapped index.
    assign out_rng   = ({1'b0, addr_q} < {1'b0, C_BASE_ADDR}) || ({1'b0, addr_q} >= C_END_ADDR);
    assign beat_resp = slverr_q ? 2'b10 : (out_rng ? 2'b11 : 2'b00);

    assign S_AXI_ARREADY = (state == ST_IDLE) && !RST;
    assign S_AXI_RVALID  = (state == ST_BEAT);
    assign S_AXI_RLAST   = S_AXI_RVALID && (cnt_q == 8'd0);
    assign S_AXI_RRESP   = S_AXI_RVALID ? beat_resp : 2'b00;
    assign S_AXI_RDATA   = (S_AXI_RVALID && beat_resp == 2'b00) ? mem_q : '0;
    assign S_AXI_RID     = id_q;
    assign S_AXI_RUSER   = '0;
    assign DBG_STATE     = state;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS,
                         S_AXI_ARUSER, S_AXI_ARADDR[1:0],
                         rd_off[AW-1:C_MEM_DEPTH_LOG2+2], rd_off[1:0]};

endmodule

// File: tb/tb_axi_inst_rom_rd.sv
// Bench for axi_inst_rom_rd: directed scenarios plus randomized bursts checked against a beat-level model.
module tb_axi_inst_rom_rd;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int          WORDS = 4096;
  localparam int          EXP_W = 35;  // {rlast, rresp, rdata}

  logic        clk, rst;
  logic        load_en;
  logic [11:0] load_addr;
  logic [31:0] load_data;
  logic [0:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [0:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  ruser;
  logic [1:0]  dbg_state;

  axi_inst_rom_rd dut (
    .CLK(clk), .RST(rst),
    .LOAD_EN(load_en), .LOAD_ADDR(load_addr), .LOAD_DATA(load_data),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
    .S_AXI_ARLOCK(2'b00), .S_AXI_ARCACHE(4'h0), .S_AXI_ARPROT(3'b000),
    .S_AXI_ARQOS(4'h0), .S_AXI_ARUSER(1'b0),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RLAST(rlast), .S_AXI_RUSER(ruser), .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready), .DBG_STATE(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [0:0]       exp_id;
  logic [31:0]      mem_m [0:WORDS-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: what beat i of a burst must carry, from the address/error rules
  function automatic logic [EXP_W-1:0] model_beat(input logic [31:0] addr, input int i,
                                                  input int len, input logic [1:0] burst,
                                                  input logic [2:0] size);
    logic [31:0] b;
    logic [1:0]  resp;
    logic [31:0] data;
    b = {addr[31:2], 2'b00} + ((burst == 2'b01) ? 32'(4 * i) : 32'd0);
    if (size != 3'b010 || burst[1])                resp = 2'b10;
    else if (b < BASE || b >= BASE + 32'(4 * WORDS)) resp = 2'b11;
    else                                           resp = 2'b00;
    data = (resp != 2'b00) ? 32'd0 : mem_m[(b - BASE) >> 2];
    return {(i == len), resp, data};
  endfunction

  // driver tasks: entered and left just after a rising edge
  task automatic load_word(input int idx, input logic [31:0] val);
    load_en   = 1'b1;
    load_addr = 12'(idx);
    load_data = val;
    mem_m[idx] = val;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic send_ar(input logic [0:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input logic [2:0] size);
    logic hs;
    hs = 1'b0;
    arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arsize = size;
    arvalid = 1'b1;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk);
      hs = arready;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    if (!hs) check("ar_timeout", 1, 0);
  endtask

  task automatic recv(input int mode);
    int k;
    k = 0;
    rready = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    while (exp_q.size() > 0 && k < 400) begin
      @(negedge clk);
      if (rvalid) begin
        check("rbeat", {29'd0, rlast, rresp, rdata}, {29'd0, exp_q[0]});
        check("rid", 64'(rid), 64'(exp_id));
        if (rready) void'(exp_q.pop_front());
      end
      @(posedge clk); #1;
      k++;
      case (mode)
        1:       rready = (k % 3 == 0);
        2:       rready = 1'($urandom_range(0, 1));
        default: rready = 1'b1;
      endcase
    end
    if (exp_q.size() > 0) begin
      check("r_timeout", 64'(exp_q.size()), 0);
      exp_q.delete();
    end
  endtask

  task automatic do_burst(input logic [0:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [2:0] size, input int mode);
    for (int i = 0; i <= len; i++) exp_q.push_back(model_beat(addr, i, len, burst, size));
    exp_id = id;
    send_ar(id, addr, len, burst, size);
    recv(mode);
    @(negedge clk);
    check("post_rvalid", 64'(rvalid), 0);
    check("post_arready", 64'(arready), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'b010; arburst = 2'b01;
    arvalid = 1'b0; rready = 1'b0;
    #3;
    check("rst_arready", 64'(arready), 0);
    check("rst_rvalid", 64'(rvalid), 0);
    check("rst_rlast", 64'(rlast), 0);
    check("rst_rdata", 64'(rdata), 0);
    check("rst_rresp", 64'(rresp), 0);
    check("rst_rid", 64'(rid), 0);
    check("rst_ruser", 64'(ruser), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("arready_after_rst", 64'(arready), 1);
    @(posedge clk); #1;

    // preload: words 0..7 known pattern, the rest random
    load_en = 1'b1;
    for (int i = 0; i < WORDS; i++) begin
      load_addr = 12'(i);
      load_data = (i < 8) ? 32'h1000_0000 + 32'(i) : $urandom;
      mem_m[i]  = load_data;
      @(posedge clk); #1;
    end
    load_en = 1'b0;

    // single read with first-beat latency
    rready = 1'b0;
    exp_q.push_back(model_beat(BASE + 32'h4, 0, 0, 2'b01, 3'b010));
    exp_id = 1'b1;
    send_ar(1'b1, BASE + 32'h4, 0, 2'b01, 3'b010);
    @(negedge clk);
    check("lat_prep_rvalid", 64'(rvalid), 0);
    check("lat_prep_arready", 64'(arready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_beat_rvalid", 64'(rvalid), 1);
    check("lat_beat_rdata", 64'(rdata), 64'h1000_0001);
    @(posedge clk); #1;
    recv(0);
    @(negedge clk);
    check("single_post_arready", 64'(arready), 1);
    @(posedge clk); #1;

    do_burst(1'b0, BASE, 7, 2'b01, 3'b010, 1);             // INCR with 1,0,0 back-pressure
    do_burst(1'b1, BASE + 32'h8, 3, 2'b00, 3'b010, 0);     // FIXED on word 2
    do_burst(1'b0, BASE + 32'h3FF8, 3, 2'b01, 3'b010, 0);  // runs off the end
    do_burst(1'b1, 32'h1000_0000, 2, 2'b01, 3'b010, 2);    // below base
    do_burst(1'b0, BASE, 2, 2'b10, 3'b010, 0);             // WRAP -> SLVERR
    do_burst(1'b1, BASE + 32'h3FFC, 1, 2'b01, 3'b011, 0);  // bad size beats decode error

    // reset during beat 3 of an 8-beat burst
    rready = 1'b1;
    send_ar(1'b1, BASE, 7, 2'b01, 3'b010);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_rvalid", 64'(rvalid), 0);
    check("midrst_rlast", 64'(rlast), 0);
    check("midrst_arready", 64'(arready), 0);
    check("midrst_rid", 64'(rid), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_rel_arready", 64'(arready), 1);
    @(posedge clk); #1;
    do_burst(1'b1, BASE, 0, 2'b01, 3'b010, 0);

    // host write to word 5 in the same cycle the first beat reads it
    exp_q.push_back({1'b0, 2'b00, mem_m[5]});
    exp_q.push_back({1'b0, 2'b00, 32'hDEAD_BEEF});
    exp_q.push_back({1'b0, 2'b00, 32'hDEAD_BEEF});
    exp_q.push_back({1'b1, 2'b00, 32'hDEAD_BEEF});
    exp_id = 1'b0;
    send_ar(1'b0, BASE + 32'h14, 3, 2'b00, 3'b010);
    load_word(5, 32'hDEAD_BEEF);
    recv(0);

    // randomized bursts
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      logic [1:0]  bt;
      logic [2:0]  sz;
      int          sel;
      for (int l = $urandom_range(0, 2); l > 0; l--)
        load_word($urandom_range(0, WORDS - 1), $urandom);
      sel = $urandom_range(0, 9);
      if (sel < 5)      a = BASE + 32'($urandom_range(0, 4 * WORDS - 1));
      else if (sel < 8) a = BASE + 32'(4 * WORDS) - 32'(4 * $urandom_range(0, 8));
      else if (sel < 9) a = BASE - 32'(4 * $urandom_range(1, 4));
      else              a = $urandom;
      bt = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 1)) : 3'b010;
      do_burst(1'($urandom_range(0, 1)), a, $urandom_range(0, 15), bt, sz, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
